// File: rtl/rm_event_lane_queue.sv
// Registered runtime-monitor event router: routes lane_ctrl probes into per-lane FIFOs with drop
// counting. Optional macro RM_EVENT_QUEUE_COALESCE_EN merges full-FIFO pushes into the tail entry.
//
// events_i[i] bit layout, MSB first: {two_lane, lane0[LANE_W], lane1[LANE_W], probe_val,
// itype[ITYPE_W]}. With default parameters each event is 12 bits wide.
module rm_event_lane_queue #(
  parameter int unsigned NUM_LANES  = 5,
  parameter int unsigned NUM_EVENTS = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_CNT_W = 8,
  parameter int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int unsigned ITYPE_W    = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  parameter int unsigned EV_W       = 2 * LANE_W + ITYPE_W + 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_EVENTS-1:0][EV_W-1:0]            events_i,
  input  logic [NUM_LANES-1:0]                       lane_en_i,
  input  logic                                       flush_i,
  output logic [NUM_LANES-1:0][NUM_EVENTS-1:0]       vec0_o,
  output logic [NUM_LANES-1:0][NUM_EVENTS-1:0]       vec1_o,
  output logic [NUM_LANES-1:0][ITYPE_W-1:0]          itype1_o,
  output logic [NUM_LANES-1:0]                       valid_o,
  input  logic [NUM_LANES-1:0]                       ready_i,
  output logic [NUM_LANES-1:0]                       full_o,
  output logic [NUM_LANES-1:0][DROP_CNT_W-1:0]       drop_cnt_o,
  output logic [NUM_LANES-1:0]                       overflow_o
);

  // FIFO_DEPTH must be a power of two so the pointers wrap for free.
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * NUM_EVENTS + ITYPE_W;

  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] new0;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] new1;
  logic [NUM_LANES-1:0][ITYPE_W-1:0]    new_itype1;

  logic                 ev_two_lane;
  logic [LANE_W-1:0]    ev_lane0;
  logic [LANE_W-1:0]    ev_lane1;
  logic                 ev_probe;
  logic [ITYPE_W-1:0]   ev_itype;

  // Routing: later (higher-index) two-lane hits overwrite itype1 of the same lane.
  always_comb begin
    new0        = '0;
    new1        = '0;
    new_itype1  = '0;
    ev_two_lane = 1'b0;
    ev_lane0    = '0;
    ev_lane1    = '0;
    ev_probe    = 1'b0;
    ev_itype    = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      ev_two_lane = events_i[i][EV_W-1];
      ev_lane0    = events_i[i][EV_W-2 -: LANE_W];
      ev_lane1    = events_i[i][EV_W-2-LANE_W -: LANE_W];
      ev_probe    = events_i[i][ITYPE_W];
      ev_itype    = events_i[i][ITYPE_W-1:0];
      if (32'(ev_lane0) < NUM_LANES) begin
        new0[ev_lane0][i] = ev_probe;
      end
      if (ev_two_lane && ev_probe && (32'(ev_lane1) < NUM_LANES)) begin
        new1[ev_lane1][i]    = 1'b1;
        new_itype1[ev_lane1] = ev_itype;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                 tail_ptr;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [DROP_CNT_W-1:0]            drop_q, drop_d;
    logic                             ovf_q, ovf_d;
    logic                             push, pop, accept, empty, full;
    logic [ENT_W-1:0]                 new_ent, tail_ent, merged_ent, head;

    assign push     = lane_en_i[l] & (|(new0[l] | new1[l]));
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop      = ~empty & ready_i[l];
    assign accept   = push & (~full | pop);
    assign new_ent  = {new0[l], new1[l], new_itype1[l]};
    assign tail_ptr = wr_ptr_q - PTR_W'(1);
    assign tail_ent = mem_q[tail_ptr];

    always_comb begin
      merged_ent = tail_ent;
      merged_ent[ENT_W-1 -: NUM_EVENTS] = tail_ent[ENT_W-1 -: NUM_EVENTS] | new0[l];
      merged_ent[ITYPE_W +: NUM_EVENTS] = tail_ent[ITYPE_W +: NUM_EVENTS] | new1[l];
      if (|new1[l]) begin
        merged_ent[ITYPE_W-1:0] = new_itype1[l];
      end
    end

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        drop_d   = '0;
        ovf_d    = 1'b0;
      end else begin
        if (accept) begin
          mem_d[wr_ptr_q] = new_ent;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else if (push) begin
`ifdef RM_EVENT_QUEUE_COALESCE_EN
          mem_d[tail_ptr] = merged_ent;
`else
          if (drop_q != '1) begin
            drop_d = drop_q + DROP_CNT_W'(1);
          end
          ovf_d = 1'b1;
`endif
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mem_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        drop_q   <= '0;
        ovf_q    <= 1'b0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        drop_q   <= drop_d;
        ovf_q    <= ovf_d;
      end
    end

    // Head is masked while empty so stale memory never leaks onto the outputs.
    assign head          = empty ? '0 : mem_q[rd_ptr_q];
    assign vec0_o[l]     = head[ENT_W-1 -: NUM_EVENTS];
    assign vec1_o[l]     = head[ITYPE_W +: NUM_EVENTS];
    assign itype1_o[l]   = head[ITYPE_W-1:0];
    assign valid_o[l]    = ~empty;
    assign full_o[l]     = full;
    assign drop_cnt_o[l] = drop_q;
    assign overflow_o[l] = ovf_q;
  end

endmodule
